// File: rtl/montgomery_const_gen.sv
// Montgomery domain constant generator.
// Produces R mod N and R^2 mod N (R = 2^WIDTH) for an odd modulus N by repeated
// modular doubling: starting from 1, after k doublings acc = 2^k mod N. The value
// after WIDTH steps is R mod N and the value after 2*WIDTH steps is R^2 mod N.
// Even moduli (including 0) are rejected in a single cycle with err set.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; accepts or rejects the request
// RUN   | one modular doubling per cycle, 2*WIDTH cycles in total
module montgomery_const_gen #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_modulus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic             o_r_valid,
    output logic [WIDTH-1:0] o_r_mod,
    output logic [WIDTH-1:0] o_r2_mod
);

    localparam int CW = $clog2(2 * WIDTH) + 1;
    // Step counts completed before the current step; WIDTH-1 means this step yields R mod N.
    localparam logic [CW-1:0] C_HALF = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_LAST = CW'(2 * WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_n;
    logic [WIDTH:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_r_valid;
    logic [WIDTH-1:0] r_r_mod;
    logic [WIDTH-1:0] r_r2_mod;

    logic             w_accept;
    logic             w_reject;
    logic             w_step;
    logic             w_half;
    logic             w_last;
    logic [WIDTH:0]   w_dbl;
    logic [WIDTH:0]   w_n_ext;
    logic [WIDTH:0]   w_acc_next;

    // Modular doubling: acc < N always holds, so 2*acc < 2N and one subtract suffices.
    always_comb begin
        w_dbl      = r_acc << 1;
        w_n_ext    = {1'b0, r_n};
        w_acc_next = (w_dbl >= w_n_ext) ? (w_dbl - w_n_ext) : w_dbl;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle control decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_step       = 1'b0;
        w_half       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_modulus[0]) begin
                        w_accept     = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_reject = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                w_half = (r_cnt == C_HALF);
                w_last = (r_cnt == C_LAST);
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath, result capture and handshake flags; done defaults low so it pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_r_valid <= 1'b0;
            r_r_mod   <= '0;
            r_r2_mod  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_n       <= i_modulus;
                // N = 1 has every residue equal to 0, so start the doubling chain there.
                r_acc     <= (i_modulus == WIDTH'(1)) ? '0 : (WIDTH + 1)'(1);
                r_cnt     <= '0;
                r_busy    <= 1'b1;
                r_err     <= 1'b0;
                r_r_valid <= 1'b0;
            end
            if (w_reject) begin
                r_done    <= 1'b1;
                r_err     <= 1'b1;
                r_r_valid <= 1'b0;
                r_r_mod   <= '0;
                r_r2_mod  <= '0;
            end
            if (w_step) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_half) begin
                    r_r_mod   <= w_acc_next[WIDTH-1:0];
                    r_r_valid <= 1'b1;
                end
                if (w_last) begin
                    r_r2_mod <= w_acc_next[WIDTH-1:0];
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_r_valid = r_r_valid;
    assign o_r_mod   = r_r_mod;
    assign o_r2_mod  = r_r2_mod;

endmodule

// File: tb/tb_montgomery_const_gen.sv
// Bench for montgomery_const_gen at WIDTH = 8, 64 and 1024. One active instance at
// a time is selected by sel; a shared monitor pops expected results off a queue at
// each done pulse and checks busy / r_valid / done timing against the accepting edge.
module tb_montgomery_const_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            sel = 0;
    logic          start = 1'b0;
    logic [1023:0] mod = '0;

    logic         b8, d8, e8, v8;
    logic [7:0]   rm8, r28;
    logic         b64, d64, e64, v64;
    logic [63:0]  rm64, r264;
    logic         bk, dk, ek, vk;
    logic [1023:0] rmk, r2k;

    montgomery_const_gen #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 0)), .i_modulus(mod[7:0]),
        .o_busy(b8), .o_done(d8), .o_err(e8), .o_r_valid(v8), .o_r_mod(rm8), .o_r2_mod(r28)
    );
    montgomery_const_gen #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 1)), .i_modulus(mod[63:0]),
        .o_busy(b64), .o_done(d64), .o_err(e64), .o_r_valid(v64), .o_r_mod(rm64), .o_r2_mod(r264)
    );
    montgomery_const_gen #(.WIDTH(1024)) u_dutk (
        .clk(clk), .rst_n(rst_n), .i_start(start && (sel == 2)), .i_modulus(mod),
        .o_busy(bk), .o_done(dk), .o_err(ek), .o_r_valid(vk), .o_r_mod(rmk), .o_r2_mod(r2k)
    );

    logic          m_busy, m_done, m_err, m_rv;
    logic [1023:0] m_rmod, m_r2mod;

    always_comb begin
        m_busy  = bk;
        m_done  = dk;
        m_err   = ek;
        m_rv    = vk;
        m_rmod  = rmk;
        m_r2mod = r2k;
        if (sel == 0) begin
            m_busy = b8; m_done = d8; m_err = e8; m_rv = v8;
            m_rmod = '0; m_rmod[7:0] = rm8;
            m_r2mod = '0; m_r2mod[7:0] = r28;
        end else if (sel == 1) begin
            m_busy = b64; m_done = d64; m_err = e64; m_rv = v64;
            m_rmod = '0; m_rmod[63:0] = rm64;
            m_r2mod = '0; m_r2mod[63:0] = r264;
        end
    end

    typedef struct {
        logic          err;
        logic [1023:0] r;
        logic [1023:0] r2;
        int            e0;
        int            w;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0] m;
        logic       err;
        logic [7:0] r;
        logic [7:0] r2;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int cur_w();
        return (sel == 0) ? 8 : (sel == 1) ? 64 : 1024;
    endfunction

    // Called just after a clock edge; the next edge is the accepting edge E0.
    task automatic issue(input logic [1023:0] m, input logic e,
                         input logic [1023:0] r, input logic [1023:0] r2);
        exp_t x;
        x.err = e;
        x.r   = r;
        x.r2  = r2;
        x.e0  = cyc + 1;
        x.w   = cur_w();
        sb.push_back(x);
        mod   = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns in the cycle where done is high (checked before advancing the clock).
    task automatic wait_done(input int bound);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done_timeout", seen, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, m_busy, 1'b0);
        chk({tag, "_done"}, m_done, 1'b0);
        chk({tag, "_err"}, m_err, 1'b0);
        chk({tag, "_rvalid"}, m_rv, 1'b0);
        chk({tag, "_rmod"}, m_rmod, '0);
        chk({tag, "_r2mod"}, m_r2mod, '0);
    endtask

    // Scoreboard monitor: timing of busy rise, r_valid rise and done, plus result values.
    initial begin
        logic pb, pv;
        exp_t e;
        pb = 1'b0;
        pv = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                pb = 1'b0;
                pv = 1'b0;
            end else begin
                if (m_done) chk("busy_in_done_cycle", m_busy, 1'b0);
                if (m_busy && !pb) begin
                    chk("busy_rise_pending", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        chk("busy_rise_cycle", cyc, sb[0].e0);
                        chk("busy_on_reject", sb[0].err, 1'b0);
                    end
                end
                if (m_rv && !pv) begin
                    chk("rvalid_rise_pending", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        chk("rvalid_rise_cycle", cyc, sb[0].e0 + sb[0].w);
                        chk("rvalid_rmod", m_rmod, sb[0].r);
                    end
                end
                if (m_done) begin
                    chk("done_pending", sb.size() > 0, 1'b1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.e0 + (e.err ? 0 : 2 * e.w));
                        chk("err", m_err, e.err);
                        chk("rvalid_at_done", m_rv, !e.err);
                        chk("r_mod", m_rmod, e.r);
                        chk("r2_mod", m_r2mod, e.r2);
                    end
                end
                pb = m_busy;
                pv = m_rv;
            end
        end
    end

    initial begin
        vec_t          vecs[10];
        logic [1023:0] big;
        logic [63:0]   n64;
        logic [127:0]  nn, rr, rr2;
        int            ndone;

        vecs[0] = '{8'd13,  1'b0, 8'd9,   8'd3};
        vecs[1] = '{8'd255, 1'b0, 8'd1,   8'd1};
        vecs[2] = '{8'd1,   1'b0, 8'd0,   8'd0};
        vecs[3] = '{8'd12,  1'b1, 8'd0,   8'd0};
        vecs[4] = '{8'd0,   1'b1, 8'd0,   8'd0};
        vecs[5] = '{8'd13,  1'b0, 8'd9,   8'd3};
        vecs[6] = '{8'd3,   1'b0, 8'd1,   8'd1};
        vecs[7] = '{8'd7,   1'b0, 8'd4,   8'd2};
        vecs[8] = '{8'd101, 1'b0, 8'd54,  8'd88};
        vecs[9] = '{8'd129, 1'b0, 8'd127, 8'd4};

        // Reset values of every instance.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_all_zero("reset");
        end
        sel = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table of 8-bit requests, each started in the done cycle of the previous one.
        foreach (vecs[i]) begin
            issue({1016'b0, vecs[i].m}, vecs[i].err, {1016'b0, vecs[i].r}, {1016'b0, vecs[i].r2});
            wait_done(40);
        end
        repeat (3) @(posedge clk);
        #1;

        // start and a modulus change during RUN are ignored.
        issue(1024'd13, 1'b0, 1024'd9, 1024'd3);
        repeat (4) @(posedge clk);
        #1;
        mod   = 1024'd11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40);
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_start_not_queued", m_busy, 1'b0);
        chk("ignored_start_rmod_held", m_rmod, 1024'd9);

        // Reset in the middle of RUN.
        mod = 1024'd13;
        issue(1024'd13, 1'b0, 1024'd9, 1024'd3);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        sb.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (m_done) ndone++;
        end
        chk("no_done_after_reset", ndone, 0);
        chk("rmod_after_reset", m_rmod, '0);

        // WIDTH = 1024 edge cases.
        sel = 2;
        @(posedge clk); #1;
        issue({1024{1'b1}}, 1'b0, 1024'd1, 1024'd1);
        wait_done(2100);
        big       = '0;
        big[1023] = 1'b1;
        big[0]    = 1'b1;
        // R = 2N - 2, so R mod N = N - 2 and R^2 mod N = 4.
        issue(big, 1'b0, big - 1024'd2, 1024'd4);
        wait_done(2100);
        repeat (2) @(posedge clk);
        #1;

        // Random odd 64-bit moduli against a direct % reference.
        sel = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 500; i++) begin
            n64 = {$urandom, $urandom} | 64'h1;
            nn  = {64'b0, n64};
            rr  = (128'd1 << 64) % nn;
            rr2 = (rr * rr) % nn;
            issue({960'b0, n64}, 1'b0, {960'b0, rr[63:0]}, {960'b0, rr2[63:0]});
            wait_done(200);
        end
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/montgomery_const_gen.md
# montgomery_const_gen

Parametrised generator of the Montgomery domain constants R mod N and R² mod N, where R = 2^WIDTH, for an odd modulus N. It computes both constants with a single WIDTH+1-bit modular-doubling datapath, so it needs no divider and no 2·WIDTH-bit multiplier. It adds a busy/done handshake, an early-valid flag for R mod N and rejection of invalid moduli. It sits ahead of the Montgomery multiplier in the RSA decryption path and is run once per key load.

## Interface
- WIDTH, 1024, operand width in bits; R = 2^WIDTH; legal range 4..4096.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- modulus  in  WIDTH  N; sampled on the accepting edge only.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse at completion or rejection.
- err  out  1  last request rejected (N even, which includes N = 0).
- r_valid  out  1  r_mod holds R mod N for the current request.
- r_mod  out  WIDTH  R mod N.
- r2_mod  out  WIDTH  R² mod N.

## Operation
- States: IDLE, RUN.
- Registers:
  - n_reg (WIDTH bits), latched N.
  - acc (WIDTH+1 bits).
  - cnt, $clog2(2·WIDTH)+1 bits.
- IDLE, start=1, modulus[0]=1 (request accepted):
  - Load n_reg ← modulus.
  - Load acc ← (modulus==1) ? 0 : 1, and cnt ← 0.
  - Clear r_valid and err.
  - Go to RUN and set busy=1.
- IDLE, start=1, modulus[0]=0 (request rejected):
  - Stay in IDLE.
  - Set err=1, pulse done.
  - Set r_mod=r2_mod=0, r_valid=0.
- RUN, one step per cycle:
  - t = acc<<1 (WIDTH+1 bits).
  - acc ← (t ≥ n_reg) ? t − n_reg : t.
  - cnt ← cnt+1.
- Invariant: acc < N before every step, so one conditional subtract is sufficient and t never exceeds WIDTH+1 bits.
- After step WIDTH completes: r_mod ← acc[WIDTH-1:0], r_valid ← 1.
- After step 2·WIDTH completes:
  - r2_mod ← acc[WIDTH-1:0].
  - busy ← 0, done pulse, go to IDLE.
- start while in RUN is ignored and not queued. modulus changes while in RUN have no effect.
- N = 1 is legal; both results are 0.
- Outputs hold their values until the next accepted start or rejected start, or reset.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State = IDLE.
  - busy, done, err, r_valid = 0.
  - r_mod, r2_mod, acc, cnt, n_reg = 0.
- Reset mid-RUN aborts the computation. Neither result is updated afterwards, and there is no done pulse.
- Accepting edge E0: busy is high in the cycle after E0. Steps occur on edges E1..E_{2·WIDTH}.
- r_valid and r_mod update on edge E_WIDTH.
- On edge E_{2·WIDTH}: r2_mod updates, done=1 and busy=0 are set together, and done lasts exactly one cycle.
- Latency from the start edge to the done cycle is 2·WIDTH cycles.
- A new start is accepted on the edge where done is high, so back-to-back requests run with no gap.
- Rejection: done and err are high in the cycle after E0, latency 1 cycle; busy never asserts.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=8, N=13:
  - r_valid rises 8 cycles after the start edge with r_mod=9.
  - done rises 16 cycles after the start edge with r2_mod=3, err=0.
- WIDTH=8, N=255: r_mod=1, r2_mod=1. Then N=1 back-to-back, with start asserted in the done cycle: r_mod=0, r2_mod=0, second done 16 cycles later.
- WIDTH=8, N=12, then N=0: each gives a done pulse the next cycle with err=1, busy never high, r_mod=r2_mod=0. A following valid N=13 clears err.
- WIDTH=8, N=13:
  - Pulse start and change modulus to 11 at cycle 5 of RUN: both are ignored and the results are still 9 and 3.
  - Assert rst_n low at cycle 10: all outputs are 0 immediately and no done pulse follows.
- WIDTH=1024, N=2^1024−1: r_mod=1, r2_mod=1, done after 2048 cycles. N=2^1023+1: r_mod=2^1023−1 and r2_mod matches a bignum reference model.
- Randomised, WIDTH=64: 500 random odd N are compared against the reference model, checking done timing, busy timing and r_valid timing.
